// File: rtl/ex_muldiv_block.sv
// ---------------------------------------------------------------------------
// ex_muldiv_block
//   EX stage of the pipelined MIPS core. It holds a single-cycle ALU, an
//   iterative unsigned multiply/divide unit (1 bit per cycle), operand
//   bypassing and its own EX/MEM pipeline register.
//
// Optional build macro:
//   EX_DIV0_FAST_EN - when defined, DIVU/REMU with a zero divisor skip the
//                     iterative phase (IDLE -> DONE). The results are the
//                     same as with the full-latency path.
//
// Ports:
//   Clock, Reset              rising-edge clock, async active-high reset
//   EX_PCplus4                PC+4, used as the result of link instructions
//   EX_RsData/RtData/Immediate operands from ID/EX
//   EX_RtReg, EX_RdReg        candidate destination registers
//   EX_RegWrite..EX_MemWrite  WB/MEM controls carried into EX/MEM
//   EX_ALUOp                  operation select (0..15)
//   EX_ALUSrc/RegDst/NoDest   operand B, destination and link selects
//   EX_Flush                  squashes the EX instruction
//   ForA, ForB                bypass select (00/11 reg, 01 WB, 10 MEM)
//   WB_WriteData              WB bypass value
//   EX_Stall                  EX busy: hold IF/ID and ID/EX
//   EX_DestReg                destination chosen in EX (combinational)
//   MEM_*                     EX/MEM register outputs
//   ZERO/NEGATIVE/CARRY/OVERFLOW  flags of the single-cycle ALU result
//   dbg_state                 FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Stall handshake: EX_Stall is a level. While it is high the hazard unit
// holds IF/ID and ID/EX unchanged and EX/MEM receives a bubble; the cycle
// EX_Stall is low, the instruction in ID/EX is consumed at the next edge.
// ---------------------------------------------------------------------------
module ex_muldiv_block #(
    parameter int                DATA_W   = 32,
    parameter int                REG_AW   = 5,
    parameter logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}}
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] EX_PCplus4,
    input  logic [DATA_W-1:0] EX_RsData,
    input  logic [DATA_W-1:0] EX_RtData,
    input  logic [DATA_W-1:0] EX_Immediate,
    input  logic [REG_AW-1:0] EX_RtReg,
    input  logic [REG_AW-1:0] EX_RdReg,
    input  logic              EX_RegWrite,
    input  logic              EX_MemtoReg,
    input  logic              EX_MemRead,
    input  logic              EX_MemWrite,
    input  logic [3:0]        EX_ALUOp,
    input  logic              EX_ALUSrc,
    input  logic              EX_RegDst,
    input  logic              EX_NoDest,
    input  logic              EX_Flush,
    input  logic [1:0]        ForA,
    input  logic [1:0]        ForB,
    input  logic [DATA_W-1:0] WB_WriteData,
    output logic              EX_Stall,
    output logic [REG_AW-1:0] EX_DestReg,
    output logic [DATA_W-1:0] MEM_ALUOut,
    output logic [DATA_W-1:0] MEM_RtData,
    output logic [REG_AW-1:0] MEM_DestReg,
    output logic              MEM_RegWrite,
    output logic              MEM_MemtoReg,
    output logic              MEM_MemRead,
    output logic              MEM_MemWrite,
    output logic              ZERO,
    output logic              NEGATIVE,
    output logic              CARRY,
    output logic              OVERFLOW,
    output logic [1:0]        dbg_state
);

    localparam int SHW = $clog2(DATA_W);
    localparam int CW  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;
    logic   start;

    // ---------------- operand bypass ----------------
    logic [DATA_W-1:0] op_a, rt_fwd, op_b;

    always_comb begin
        case (ForA)
            2'b01:   op_a = WB_WriteData;
            2'b10:   op_a = MEM_ALUOut;
            default: op_a = EX_RsData;
        endcase
        case (ForB)
            2'b01:   rt_fwd = WB_WriteData;
            2'b10:   rt_fwd = MEM_ALUOut;
            default: rt_fwd = EX_RtData;
        endcase
        op_b = EX_ALUSrc ? EX_Immediate : rt_fwd;
    end

    // ---------------- single-cycle ALU ----------------
    // Shift amount is Immediate[10:6] truncated to log2(DATA_W) bits; bits
    // that would fall outside a narrow datapath read as zero.
    logic [SHW-1:0] shamt;
    for (genvar gi = 0; gi < SHW; gi++) begin : g_shamt
        if (gi < 5 && gi + 6 < DATA_W) begin : g_bit
            assign shamt[gi] = EX_Immediate[gi+6];
        end else begin : g_zero
            assign shamt[gi] = 1'b0;
        end
    end

    logic [DATA_W:0]   add_full, sub_full;
    logic [DATA_W-1:0] sll_res, srl_res, sra_res, alu_res;

    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    // SUB as A + ~B + 1 so the carry-out is the not-borrow flag.
    assign sub_full = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
    // Shifts operate on operand B (the Rt value for R-type shifts).
    assign sll_res  = op_b << shamt;
    assign srl_res  = op_b >> shamt;
    assign sra_res  = $signed(op_b) >>> shamt;

    always_comb begin
        alu_res = '0;
        case (EX_ALUOp)
            4'd0: alu_res = add_full[DATA_W-1:0];
            4'd1: alu_res = sub_full[DATA_W-1:0];
            4'd2: alu_res = op_a & op_b;
            4'd3: alu_res = op_a | op_b;
            4'd4: alu_res = op_a ^ op_b;
            4'd5: alu_res = ~(op_a | op_b);
            4'd6: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd7: alu_res = sll_res;
            4'd8: alu_res = srl_res;
            4'd9: alu_res = sra_res;
            default: alu_res = '0;  // 10..13 come from the iterative unit
        endcase
    end

    always_comb begin
        ZERO     = (alu_res == '0);
        NEGATIVE = alu_res[DATA_W-1];
        CARRY    = 1'b0;
        OVERFLOW = 1'b0;
        if (EX_ALUOp == 4'd0) begin
            CARRY    = add_full[DATA_W];
            OVERFLOW = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                       (add_full[DATA_W-1] != op_a[DATA_W-1]);
        end else if (EX_ALUOp == 4'd1) begin
            CARRY    = sub_full[DATA_W];
            OVERFLOW = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                       (sub_full[DATA_W-1] != op_a[DATA_W-1]);
        end
    end

    // ---------------- destination / link ----------------
    always_comb begin
        if (EX_NoDest)
            EX_DestReg = EX_RegWrite ? LINK_REG : '0;
        else
            EX_DestReg = EX_RegDst ? EX_RdReg : EX_RtReg;
    end

    logic [DATA_W-1:0] ex_result;
    assign ex_result = EX_NoDest ? EX_PCplus4 : alu_res;

    // ---------------- iterative multiply / divide ----------------
    // Opcodes 10..13: bit 2 selects divide, bit 0 selects the high half
    // (MULHI product bits / REMU remainder).
    logic is_md;
    assign is_md = (EX_ALUOp >= 4'd10) && (EX_ALUOp <= 4'd13);

`ifdef EX_DIV0_FAST_EN
    logic div0_start;
    assign div0_start = EX_ALUOp[2] && (op_b == '0);
`endif

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] md_b, md_hi, md_lo, md_rt, md_pc4;
    logic [REG_AW-1:0] md_dest;
    logic              md_div, md_hi_sel, md_nodest;
    logic              md_regwrite, md_memtoreg, md_memread, md_memwrite;

    // Multiply: {md_hi, md_lo} is the partial product, md_lo starts as the
    // multiplier and is shifted out LSB first.
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] mul_hi_n, mul_lo_n;
    // Restoring divide: md_hi is the partial remainder, md_lo shifts the
    // dividend out MSB first and the quotient bits in LSB first. A zero
    // divisor naturally yields quotient all-ones and remainder = dividend.
    logic [DATA_W:0]   div_sh;
    logic [DATA_W-1:0] div_diff, div_hi_n, div_lo_n;
    logic              div_ge;

    always_comb begin
        mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : {(DATA_W+1){1'b0}});
        mul_hi_n = mul_sum[DATA_W:1];
        mul_lo_n = {mul_sum[0], md_lo[DATA_W-1:1]};

        div_sh   = {md_hi, md_lo[DATA_W-1]};
        div_ge   = (div_sh >= {1'b0, md_b});
        // When div_ge holds the difference is below md_b, so W bits suffice.
        div_diff = div_sh[DATA_W-1:0] - md_b;
        div_hi_n = div_ge ? div_diff : div_sh[DATA_W-1:0];
        div_lo_n = {md_lo[DATA_W-2:0], div_ge};
    end

    logic [DATA_W-1:0] md_res;
    assign md_res = md_nodest ? md_pc4 : (md_hi_sel ? md_hi : md_lo);

    // ---------------- FSM ----------------
    always_comb begin
        state_n = state;
        start   = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_md && !EX_Flush) begin
                    start   = 1'b1;
                    state_n = S_BUSY;
`ifdef EX_DIV0_FAST_EN
                    if (div0_start)
                        state_n = S_DONE;
`endif
                end
            end
            S_BUSY: begin
                if (cnt == CW'(1))
                    state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (EX_Flush)
            state_n = S_IDLE;
        // Flush wins over start and over the busy phase.
        EX_Stall = !Reset && !EX_Flush &&
                   ((state == S_IDLE && is_md) || state == S_BUSY);
    end

    assign dbg_state = state;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            md_b        <= '0;
            md_hi       <= '0;
            md_lo       <= '0;
            md_rt       <= '0;
            md_pc4      <= '0;
            md_dest     <= '0;
            md_div      <= 1'b0;
            md_hi_sel   <= 1'b0;
            md_nodest   <= 1'b0;
            md_regwrite <= 1'b0;
            md_memtoreg <= 1'b0;
            md_memread  <= 1'b0;
            md_memwrite <= 1'b0;
        end else begin
            state <= state_n;
            if (EX_Flush) begin
                cnt <= '0;
            end else if (start) begin
                // Forwarded operands are captured here only.
                cnt         <= CW'(DATA_W);
                md_b        <= op_b;
                md_hi       <= '0;
                md_lo       <= op_a;
                md_rt       <= rt_fwd;
                md_pc4      <= EX_PCplus4;
                md_dest     <= EX_DestReg;
                md_div      <= EX_ALUOp[2];
                md_hi_sel   <= EX_ALUOp[0];
                md_nodest   <= EX_NoDest;
                md_regwrite <= EX_RegWrite;
                md_memtoreg <= EX_MemtoReg;
                md_memread  <= EX_MemRead;
                md_memwrite <= EX_MemWrite;
`ifdef EX_DIV0_FAST_EN
                if (div0_start) begin
                    md_hi <= op_a;
                    md_lo <= '1;
                end
`endif
            end else if (state == S_BUSY) begin
                cnt   <= cnt - CW'(1);
                md_hi <= md_div ? div_hi_n : mul_hi_n;
                md_lo <= md_div ? div_lo_n : mul_lo_n;
            end
        end
    end

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            MEM_ALUOut   <= '0;
            MEM_RtData   <= '0;
            MEM_DestReg  <= '0;
            MEM_RegWrite <= 1'b0;
            MEM_MemtoReg <= 1'b0;
            MEM_MemRead  <= 1'b0;
            MEM_MemWrite <= 1'b0;
        end else if (EX_Flush || EX_Stall) begin
            MEM_ALUOut   <= '0;
            MEM_RtData   <= '0;
            MEM_DestReg  <= '0;
            MEM_RegWrite <= 1'b0;
            MEM_MemtoReg <= 1'b0;
            MEM_MemRead  <= 1'b0;
            MEM_MemWrite <= 1'b0;
        end else if (state == S_DONE) begin
            MEM_ALUOut   <= md_res;
            MEM_RtData   <= md_rt;
            MEM_DestReg  <= md_dest;
            MEM_RegWrite <= md_regwrite;
            MEM_MemtoReg <= md_memtoreg;
            MEM_MemRead  <= md_memread;
            MEM_MemWrite <= md_memwrite;
        end else begin
            MEM_ALUOut   <= ex_result;
            MEM_RtData   <= rt_fwd;
            MEM_DestReg  <= EX_DestReg;
            MEM_RegWrite <= EX_RegWrite;
            MEM_MemtoReg <= EX_MemtoReg;
            MEM_MemRead  <= EX_MemRead;
            MEM_MemWrite <= EX_MemWrite;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_block.sv
`timescale 1ns/1ps
module tb_ex_muldiv_block;

    localparam int W      = 32;
    localparam int RAW    = 5;
    localparam int MD_LAT = W + 1;   // EX_Stall high cycles for ops 10..13
`ifdef EX_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = W + 1;
`endif

    logic           Clock, Reset;
    logic [W-1:0]   EX_PCplus4, EX_RsData, EX_RtData, EX_Immediate, WB_WriteData;
    logic [RAW-1:0] EX_RtReg, EX_RdReg;
    logic           EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite;
    logic [3:0]     EX_ALUOp;
    logic           EX_ALUSrc, EX_RegDst, EX_NoDest, EX_Flush;
    logic [1:0]     ForA, ForB;
    logic           EX_Stall;
    logic [RAW-1:0] EX_DestReg, MEM_DestReg;
    logic [W-1:0]   MEM_ALUOut, MEM_RtData;
    logic           MEM_RegWrite, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite;
    logic           ZERO, NEGATIVE, CARRY, OVERFLOW;
    logic [1:0]     dbg_state;

    ex_muldiv_block dut (
        .Clock(Clock), .Reset(Reset),
        .EX_PCplus4(EX_PCplus4), .EX_RsData(EX_RsData), .EX_RtData(EX_RtData),
        .EX_Immediate(EX_Immediate), .EX_RtReg(EX_RtReg), .EX_RdReg(EX_RdReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_ALUOp(EX_ALUOp), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
        .EX_NoDest(EX_NoDest), .EX_Flush(EX_Flush), .ForA(ForA), .ForB(ForB),
        .WB_WriteData(WB_WriteData), .EX_Stall(EX_Stall), .EX_DestReg(EX_DestReg),
        .MEM_ALUOut(MEM_ALUOut), .MEM_RtData(MEM_RtData), .MEM_DestReg(MEM_DestReg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .ZERO(ZERO), .NEGATIVE(NEGATIVE), .CARRY(CARRY), .OVERFLOW(OVERFLOW),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bubble(input string name);
        check({name, "_ctl"}, {MEM_RegWrite, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite}, 4'b0000);
        check({name, "_data"}, MEM_ALUOut, '0);
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [1:0]   fora;
        logic [W-1:0] a, b, imm, wb, pc4;
        logic         alusrc, nodest;
        logic [W-1:0] exp_res;
        logic         chk_flags;
        logic [3:0]   exp_flags;   // {ZERO, NEGATIVE, CARRY, OVERFLOW}
        int           exp_lat;     // cycles with EX_Stall high
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] imm, input logic alusrc, input logic [W-1:0] res,
                                input logic chk, input logic [3:0] fl, input int lat);
        vec_t v;
        v.op = op; v.fora = 2'b00; v.a = a; v.b = b; v.imm = imm; v.wb = '0; v.pc4 = '0;
        v.alusrc = alusrc; v.nodest = 1'b0; v.exp_res = res; v.chk_flags = chk;
        v.exp_flags = fl; v.exp_lat = lat;
        return v;
    endfunction

    // Reference for the multi-cycle ops, using wide native arithmetic.
    function automatic logic [W-1:0] model_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'd10:   return p[W-1:0];
            4'd11:   return p[2*W-1:W];
            4'd12:   return (b == '0) ? '1 : a / b;
            4'd13:   return (b == '0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive_idle();
        EX_ALUOp = 4'd0; ForA = 2'b00; ForB = 2'b00; EX_RsData = '0; EX_RtData = '0;
        EX_Immediate = '0; EX_ALUSrc = 1'b0; WB_WriteData = '0; EX_NoDest = 1'b0;
        EX_PCplus4 = '0; EX_RegWrite = 1'b0; EX_RegDst = 1'b1; EX_RdReg = '0; EX_RtReg = '0;
        EX_MemtoReg = 1'b0; EX_MemRead = 1'b0; EX_MemWrite = 1'b0; EX_Flush = 1'b0;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_vec(input vec_t v, input logic [RAW-1:0] rd);
        int             stall_cnt;
        logic           bubble_ok;
        logic [W-1:0]   exp;
        logic [RAW-1:0] exp_dest;
        EX_ALUOp = v.op; ForA = v.fora; ForB = 2'b00; EX_RsData = v.a; EX_RtData = v.b;
        EX_Immediate = v.imm; EX_ALUSrc = v.alusrc; WB_WriteData = v.wb;
        EX_NoDest = v.nodest; EX_PCplus4 = v.pc4; EX_RegWrite = 1'b1; EX_RegDst = 1'b1;
        EX_RdReg = rd; EX_RtReg = ~rd; EX_MemtoReg = 1'b0; EX_MemRead = 1'b0;
        EX_MemWrite = 1'b0; EX_Flush = 1'b0;
        exp_dest = v.nodest ? 5'd31 : rd;
        exp_q.push_back(v.exp_res);
        #1;
        check("ex_dest", EX_DestReg, exp_dest);
        if (v.chk_flags)
            check("flags", {ZERO, NEGATIVE, CARRY, OVERFLOW}, v.exp_flags);
        stall_cnt = 0;
        bubble_ok = 1'b1;
        while (EX_Stall === 1'b1 && stall_cnt < 4 * W) begin
            stall_cnt++;
            @(negedge Clock); #2;
            if ({MEM_RegWrite, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite} !== 4'b0 || MEM_ALUOut !== '0)
                bubble_ok = 1'b0;
        end
        check("stall_cycles", stall_cnt, v.exp_lat);
        if (stall_cnt > 0)
            check("stall_bubble", bubble_ok, 1'b1);
        @(negedge Clock); #2;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            exp = exp_q.pop_front();
            check("result", MEM_ALUOut, exp);
        end
        check("regwrite", MEM_RegWrite, 1'b1);
        check("mem_dest", MEM_DestReg, exp_dest);
        check("rt_data", MEM_RtData, v.b);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[23];

    initial begin
        vec_t v;
        int   n;
        logic late;

        drive_idle();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock); #2;
        check("rst_stall", EX_Stall, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        check_bubble("rst_mem");
        check("rst_dest", MEM_DestReg, '0);
        Reset = 1'b0;

        //            op     a             b             imm          src  result        chk  flags    lat
        tbl[0]  = mk(4'd0,  32'h7FFFFFFF, 32'h1,        32'h0,       1'b0, 32'h80000000, 1'b1, 4'b0101, 0);
        tbl[1]  = mk(4'd1,  32'h5,        32'h7,        32'h0,       1'b0, 32'hFFFFFFFE, 1'b1, 4'b0100, 0);
        tbl[2]  = mk(4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,       1'b0, 32'h00F000F0, 1'b1, 4'b0000, 0);
        tbl[3]  = mk(4'd3,  32'h00000F00, 32'h000000F0, 32'h0,       1'b0, 32'h00000FF0, 1'b1, 4'b0000, 0);
        tbl[4]  = mk(4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0,       1'b0, 32'hF0F00F0F, 1'b1, 4'b0100, 0);
        tbl[5]  = mk(4'd5,  32'h0,        32'h0,        32'h0,       1'b0, 32'hFFFFFFFF, 1'b1, 4'b0100, 0);
        tbl[6]  = mk(4'd6,  32'hFFFFFFFF, 32'h1,        32'h0,       1'b0, 32'h1,        1'b1, 4'b0000, 0);
        tbl[7]  = mk(4'd7,  32'h0,        32'h1,        32'h7C0,     1'b0, 32'h80000000, 1'b1, 4'b0100, 0);
        tbl[8]  = mk(4'd8,  32'h0,        32'h80000000, 32'h900,     1'b0, 32'h08000000, 1'b1, 4'b0000, 0);
        tbl[9]  = mk(4'd9,  32'h0,        32'h80000000, 32'h100,     1'b0, 32'hF8000000, 1'b1, 4'b0100, 0);
        tbl[10] = mk(4'd14, 32'h1234,     32'h5678,     32'h0,       1'b0, 32'h0,        1'b1, 4'b1000, 0);
        tbl[11] = mk(4'd0,  32'hA,        32'h55,       32'hFFFFFFFF,1'b1, 32'h9,        1'b1, 4'b0010, 0);
        tbl[12] = mk(4'd0,  32'h10,       32'h0,        32'h0,       1'b0, 32'h10,       1'b1, 4'b0000, 0);
        tbl[13] = mk(4'd1,  32'hDEADBEEF, 32'h5,        32'h0,       1'b0, 32'hB,        1'b1, 4'b0010, 0);
        tbl[13].fora = 2'b10;   // MEM bypass: previous result 0x10
        tbl[14] = mk(4'd2,  32'hFF,       32'hAA,       32'h1,       1'b1, 32'h1,        1'b1, 4'b0000, 0);
        tbl[14].fora = 2'b01; tbl[14].wb = 32'h3;
        tbl[15] = mk(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,       1'b0, 32'h1,        1'b0, 4'b0000, MD_LAT);
        tbl[16] = mk(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,       1'b0, 32'hFFFFFFFE, 1'b0, 4'b0000, MD_LAT);
        tbl[17] = mk(4'd12, 32'd100,      32'd7,        32'h0,       1'b0, 32'd14,       1'b0, 4'b0000, MD_LAT);
        tbl[18] = mk(4'd13, 32'd100,      32'd7,        32'h0,       1'b0, 32'd2,        1'b0, 4'b0000, MD_LAT);
        tbl[19] = mk(4'd12, 32'd5,        32'd0,        32'h0,       1'b0, 32'hFFFFFFFF, 1'b0, 4'b0000, DIV0_LAT);
        tbl[20] = mk(4'd13, 32'd5,        32'd0,        32'h0,       1'b0, 32'd5,        1'b0, 4'b0000, DIV0_LAT);
        tbl[21] = mk(4'd0,  32'h1,        32'h2,        32'h0,       1'b0, 32'h00400008, 1'b1, 4'b0000, 0);
        tbl[21].nodest = 1'b1; tbl[21].pc4 = 32'h00400008;
        tbl[22] = mk(4'd15, 32'h77,       32'h33,       32'h0,       1'b0, 32'h0,        1'b1, 4'b1000, 0);

        @(negedge Clock); #2;
        for (int i = 0; i < 23; i++)
            run_vec(tbl[i], RAW'(i + 1));

        // Random multiply/divide against the wide-arithmetic reference.
        for (int i = 0; i < 6; i++) begin
            v = mk(4'($urandom_range(10, 13)), $urandom, $urandom, 32'h0, 1'b0, '0, 1'b0, 4'b0, MD_LAT);
            if (v.op >= 4'd12)
                v.b = 32'($urandom_range(1, 1000));
            v.exp_res = model_md(v.op, v.a, v.b);
            run_vec(v, RAW'(i + 2));
        end

        // Flush during BUSY of DIVU: stall drops at once, no late write-back.
        EX_ALUOp = 4'd12; EX_RsData = 32'd100; EX_RtData = 32'd7; EX_RegWrite = 1'b1;
        EX_RdReg = 5'd9; EX_ALUSrc = 1'b0; ForA = 2'b00; EX_NoDest = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock); #2;
        check("flush_pre_stall", EX_Stall, 1'b1);
        EX_Flush = 1'b1;
        #1;
        check("flush_stall", EX_Stall, 1'b0);
        @(negedge Clock); #2;
        check_bubble("flush_mem");
        check("flush_state", dbg_state, 2'd0);
        drive_idle();
        late = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge Clock); #2;
            if (MEM_RegWrite !== 1'b0 || EX_Stall !== 1'b0)
                late = 1'b1;
        end
        check("flush_no_late_wb", late, 1'b0);

        // Flush beats start: a DIVU presented with Flush never begins.
        EX_ALUOp = 4'd12; EX_RegWrite = 1'b1; EX_Flush = 1'b1;
        #1;
        check("flush_start_stall", EX_Stall, 1'b0);
        @(negedge Clock); #2;
        check("flush_start_state", dbg_state, 2'd0);
        check("flush_start_wb", MEM_RegWrite, 1'b0);
        drive_idle();
        @(negedge Clock); #2;

        // Forwarded operand is sampled only in the start cycle.
        EX_ALUOp = 4'd10; ForA = 2'b01; WB_WriteData = 32'd6; EX_RsData = 32'd1000;
        EX_RtData = 32'd7; EX_RegWrite = 1'b1; EX_RdReg = 5'd4;
        exp_q.push_back(32'd42);
        @(negedge Clock); #2;
        WB_WriteData = 32'd100;
        n = 0;
        while (EX_Stall === 1'b1 && n < 4 * W) begin
            @(negedge Clock); #2;
            n++;
        end
        check("fwd_hold_lat", n, W);
        @(negedge Clock); #2;
        check("fwd_hold_result", MEM_ALUOut, exp_q.pop_front());
        drive_idle();
        @(negedge Clock); #2;

        // Reset in the middle of BUSY.
        EX_ALUOp = 4'd10; EX_RsData = 32'd3; EX_RtData = 32'd5; EX_RegWrite = 1'b1; EX_RdReg = 5'd6;
        repeat (5) @(posedge Clock);
        #2;
        check("midbusy_state", dbg_state, 2'd1);
        Reset = 1'b1;
        #1;
        check("midrst_stall", EX_Stall, 1'b0);
        check("midrst_state", dbg_state, 2'd0);
        check_bubble("midrst_mem");
        check("midrst_dest", {MEM_DestReg, MEM_RtData}, '0);
        drive_idle();
        @(negedge Clock); #2;
        Reset = 1'b0;
        run_vec(mk(4'd0, 32'h20, 32'h22, 32'h0, 1'b0, 32'h42, 1'b1, 4'b0000, 0), 5'd3);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
